// File: rtl/addsub_cla_pipe.sv
// Pipelined add/subtract unit: WIDTH bits split into STAGES carry-lookahead segments,
// one segment per register stage, with valid/ready flow control and a global enable.
module addsub_cla_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_r,
  output logic             cout_r,
  output logic             ovf_r
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Stage k holds a beat whose segments 0..k-1 are already summed into acc.
  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] cy_q, cy_d;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic [WIDTH-1:0]  acc_q [STAGES];
  logic [WIDTH-1:0]  acc_d [STAGES];

  logic [SEG:0]      seg_c   [STAGES];
  logic [WIDTH-1:0]  seg_acc [STAGES];

  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              adv;

  // Carries c[0..SEG] of one segment, each written as a flat generate/propagate product.
  function automatic logic [SEG:0] cla_carries(input logic [SEG-1:0] g,
                                               input logic [SEG-1:0] p,
                                               input logic           ci);
    logic [SEG:0] c;
    logic         term;
    c    = '0;
    c[0] = ci;
    for (int i = 1; i <= SEG; i++) begin
      term = ci;
      for (int j = 0; j < i; j++) term = term & p[j];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_c[k]   = cla_carries(opa_q[k][k*SEG +: SEG] & opb_q[k][k*SEG +: SEG],
                               opa_q[k][k*SEG +: SEG] ^ opb_q[k][k*SEG +: SEG],
                               cy_q[k]);
      seg_acc[k] = acc_q[k];
      seg_acc[k][k*SEG +: SEG] = opa_q[k][k*SEG +: SEG] ^ opb_q[k][k*SEG +: SEG]
                                 ^ seg_c[k][SEG-1:0];
    end
  end

  assign adv      = enable & (~out_valid_q | out_ready);
  assign in_ready = adv;

  always_comb begin
    vld_d       = vld_q;
    cy_d        = cy_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    if (adv) begin
      vld_d[0] = in_valid;
      opa_d[0] = a;
      opb_d[0] = sub ? ~b : b;
      cy_d[0]  = sub ? ~cin : cin;
      acc_d[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
        vld_d[k] = vld_q[k-1];
        opa_d[k] = opa_q[k-1];
        opb_d[k] = opb_q[k-1];
        cy_d[k]  = seg_c[k-1][SEG];
        acc_d[k] = seg_acc[k-1];
      end
      out_valid_d = vld_q[LAST];
      if (vld_q[LAST]) begin
        sum_d  = seg_acc[LAST];
        cout_d = seg_c[LAST][SEG];
        ovf_d  = seg_c[LAST][SEG] ^ seg_c[LAST][SEG-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
    end
  end

  // Payload needs no reset: it is qualified by vld_q everywhere it is consumed.
  always_ff @(posedge clk) begin
    cy_q  <= cy_d;
    opa_q <= opa_d;
    opb_q <= opb_d;
    acc_q <= acc_d;
  end

  assign out_valid = out_valid_q;
  assign sum_r     = sum_q;
  assign cout_r    = cout_q;
  assign ovf_r     = ovf_q;

endmodule

// File: tb/tb_addsub_cla_pipe.sv
// Scoreboard bench: three configurations share one stimulus stream; each has its own
// expected-result queue filled on accept and drained by a monitor on retire.
module tb_addsub_cla_pipe;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          seen;
  } exp_t;

  logic        clk, rst, enable, in_valid, out_ready, cin, sub;
  logic [63:0] a, b;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          lat_chk = 0;
  bit          final_chk = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 1) ? 64 : 32;
    localparam int S = (g == 0) ? 4 : ((g == 1) ? 8 : 1);

    logic         in_ready, out_valid, cout_r, ovf_r;
    logic [W-1:0] sum_r;
    exp_t         q[$];
    bit           rst_d1 = 0;
    bit           fin_done = 0;

    addsub_cla_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(rst), .enable(enable),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a[W-1:0]), .b(b[W-1:0]), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum_r(sum_r), .cout_r(cout_r), .ovf_r(ovf_r)
    );

    // Exact arithmetic at W+2 bits: unsigned for carry/no-borrow, sign-extended for range.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb, input int cy);
      logic [W+1:0] xu, yu, xs, ys, u, s, c1;
      exp_t e;
      xu = {2'b00, x};
      yu = {2'b00, y};
      xs = {{2{x[W-1]}}, x};
      ys = {{2{y[W-1]}}, y};
      c1 = (W+2)'(ci);
      if (sb) begin
        u = {2'b01, {W{1'b0}}} + xu - yu - c1;
        s = xs - ys - c1;
      end else begin
        u = xu + yu + c1;
        s = xs + ys + c1;
      end
      e.sum        = '0;
      e.sum[W-1:0] = u[W-1:0];
      e.cout       = u[W];
      e.ovf        = !(s[W+1:W-1] == 3'b000 || s[W+1:W-1] == 3'b111);
      e.acc        = cy;
      e.seen       = 0;
      return e;
    endfunction

    always @(negedge clk) begin
      if (rst_d1) begin
        tests++;
        if (out_valid || sum_r != '0 || cout_r || ovf_r) begin
          fails++;
          $display("FAIL reset_out[S=%0d] got valid=%b sum=%h cout=%b ovf=%b, want all zero",
                   S, out_valid, sum_r, cout_r, ovf_r);
        end
      end
      rst_d1 = rst;
      if (rst) begin
        q.delete();
      end else begin
        tests++;
        if (in_ready != (enable && (!out_valid || out_ready))) begin
          fails++;
          $display("FAIL in_ready[S=%0d] cyc=%0d got %b (enable=%b out_valid=%b out_ready=%b)",
                   S, cyc, in_ready, enable, out_valid, out_ready);
        end
        if (out_valid) begin
          tests++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL spurious[S=%0d] cyc=%0d out_valid with nothing expected, sum=%h",
                     S, cyc, sum_r);
          end else begin
            if (64'(sum_r) != q[0].sum || cout_r != q[0].cout || ovf_r != q[0].ovf) begin
              fails++;
              $display("FAIL result[S=%0d] cyc=%0d got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                       S, cyc, sum_r, cout_r, ovf_r, q[0].sum[W-1:0], q[0].cout, q[0].ovf);
            end
            if (lat_chk && !q[0].seen) begin
              tests++;
              if (cyc - q[0].acc != S + 1) begin
                fails++;
                $display("FAIL latency[S=%0d] got %0d cycles want %0d",
                         S, cyc - q[0].acc - 1, S);
              end
            end
            q[0].seen = 1;
            if (out_ready && enable) void'(q.pop_front());
          end
        end
        if (in_valid && in_ready) q.push_back(model(a[W-1:0], b[W-1:0], cin, sub, cyc));
      end
      if (final_chk && !fin_done) begin
        fin_done = 1;
        tests++;
        if (q.size() != 0) begin
          fails++;
          $display("FAIL drain[S=%0d] got %0d results outstanding want 0", S, q.size());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic beat(input logic [63:0] x, input logic [63:0] y,
                      input logic ci, input logic sb);
    in_valid = 1'b1;
    a = x;
    b = y;
    cin = ci;
    sub = sb;
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return 64'h8000_0000_8000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic rand_in();
    a = rand_op();
    b = rand_op();
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    cin = 1'b0;
    sub = 1'b0;
    idle(3);
    rst = 1'b0;

    // Isolated beats: values, carry across every segment, overflow, latency.
    lat_chk = 1;
    beat(64'h1, 64'h2, 1'b0, 1'b0);                  idle(12);
    beat('1, 64'h0, 1'b1, 1'b0);                     idle(12);
    beat(64'h8000_0000_8000_0000, 64'h1, 1'b0, 1'b1); idle(12);
    beat(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1); idle(12);
    beat(64'h3, 64'h5, 1'b0, 1'b1);                  idle(12);
    beat(64'h7FFF_FFFF_7FFF_FFFF, 64'h1, 1'b0, 1'b0); idle(12);
    lat_chk = 0;

    // Back-to-back stream with a 3-cycle consumer stall.
    for (int i = 0; i < 13; i++) begin
      in_valid = (i < 8);
      rand_in();
      out_ready = !(i >= 5 && i < 8);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(12);

    // Global freeze for 2 cycles with the pipeline full.
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      rand_in();
      enable = !(i == 6 || i == 7);
      step();
    end
    enable = 1'b1;
    in_valid = 1'b0;
    idle(12);

    // Reset with beats in flight, then one fresh beat.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_in();
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    beat(64'h7, 64'h9, 1'b1, 1'b0);
    idle(12);

    // Random sweep with random enable, backpressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      rand_in();
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    enable = 1'b1;
    out_ready = 1'b1;
    idle(30);
    final_chk = 1;
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
